// File: rtl/framebuffer_writer.sv
// Write-side framebuffer engine: walks the host window, packs RGB565 pixels into
// 64-bit words and drains 32-pixel bursts to PSRAM through a ping-pong buffer pair.
module framebuffer_writer (
    input  logic        i_psram_clk,
    input  logic        i_psram_rst,
    input  logic [10:0] i_reg_stride,
    input  logic [10:0] i_reg_x0,
    input  logic [10:0] i_reg_x1,
    input  logic [10:0] i_reg_y0,
    input  logic [10:0] i_reg_y1,
    input  logic        i_win_start,
    input  logic        i_pix_valid,
    input  logic [15:0] i_pix_data,
    output logic        o_psram_req,
    input  logic        i_psram_gnt,
    output logic [20:0] o_psram_addr,
    input  logic        i_psram_data_req,
    output logic [63:0] o_psram_data,
    output logic        o_busy,
    output logic        o_overflow,
    output logic        o_align_err
);

    typedef enum logic [1:0] {IDLE, REQ, DATA} wr_state_t;

    wr_state_t   state_q, state_d;
    logic [2:0]  beat_q;

    logic [10:0] stride_q, x0_q, x1_q, y0_q, y1_q;
    logic [10:0] x_q, y_q;
    logic [20:0] base0_q, line_base_q;
    logic        start_d_q, win_ok_q, overflow_q, align_err_q;
    logic [47:0] pack_q;

    logic        fill_sel_q, drain_sel_q;
    logic [1:0]  full_q;
    logic [20:0] addr_q [2];
    logic [63:0] buf_mem [2][8];

    logic [4:0]  width_lsb;
    logic        aligned;
    logic        release_now, fill_blocked, pix_take, pix_store, word_done, burst_done;

    assign width_lsb = i_reg_x1[4:0] - i_reg_x0[4:0] + 5'd1;
    assign aligned   = (i_reg_x0[4:0] == 5'd0) && (width_lsb == 5'd0);

    // A buffer being released this cycle may be refilled in the same cycle.
    assign release_now  = (state_q == DATA) && i_psram_data_req && (beat_q == 3'd7);
    assign fill_blocked = full_q[fill_sel_q] && !(release_now && (drain_sel_q == fill_sel_q));
    assign pix_take     = i_pix_valid && win_ok_q && !i_win_start;
    assign pix_store    = pix_take && !fill_blocked;
    assign word_done    = pix_store && (x_q[1:0] == 2'd3);
    assign burst_done   = word_done && (x_q[4:2] == 3'd7);

    // Window latch, line-base multiply pipeline and raster cursor.
    always_ff @(posedge i_psram_clk) begin
        if (i_psram_rst) begin
            stride_q    <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            base0_q     <= '0;
            line_base_q <= '0;
            start_d_q   <= 1'b0;
            win_ok_q    <= 1'b0;
            overflow_q  <= 1'b0;
            align_err_q <= 1'b0;
            pack_q      <= '0;
        end else begin
            start_d_q <= i_win_start;
            if (i_win_start) begin
                stride_q <= i_reg_stride;
                x0_q     <= i_reg_x0;
                x1_q     <= i_reg_x1;
                y0_q     <= i_reg_y0;
                y1_q     <= i_reg_y1;
                x_q      <= i_reg_x0;
                y_q      <= i_reg_y0;
                base0_q  <= 21'(i_reg_y0) * 21'(i_reg_stride);
                win_ok_q <= aligned;
                pack_q   <= '0;
                if (!aligned) begin
                    align_err_q <= 1'b1;
                end
            end else begin
                if (start_d_q) begin
                    line_base_q <= base0_q;
                end
                if (pix_take) begin
                    if (fill_blocked) begin
                        overflow_q <= 1'b1;
                    end
                    // Dropped pixels still advance the cursor so later ones land in place.
                    if (x_q == x1_q) begin
                        x_q <= x0_q;
                        if (y_q == y1_q) begin
                            y_q         <= y0_q;
                            line_base_q <= base0_q;
                        end else begin
                            y_q         <= y_q + 11'd1;
                            line_base_q <= line_base_q + 21'(stride_q);
                        end
                    end else begin
                        x_q <= x_q + 11'd1;
                    end
                    if (pix_store) begin
                        case (x_q[1:0])
                            2'd0:    pack_q[15:0]  <= i_pix_data;
                            2'd1:    pack_q[31:16] <= i_pix_data;
                            2'd2:    pack_q[47:32] <= i_pix_data;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge i_psram_clk) begin
        if (word_done) begin
            buf_mem[fill_sel_q][x_q[4:2]] <= {i_pix_data, pack_q};
        end
    end

    // Full flags: a release and a refill of the same buffer in one cycle leaves it full.
    always_ff @(posedge i_psram_clk) begin
        if (i_psram_rst) begin
            full_q      <= '0;
            fill_sel_q  <= 1'b0;
            drain_sel_q <= 1'b0;
            addr_q[0]   <= '0;
            addr_q[1]   <= '0;
        end else begin
            if (release_now) begin
                full_q[drain_sel_q] <= 1'b0;
                drain_sel_q         <= ~drain_sel_q;
            end
            if (burst_done) begin
                full_q[fill_sel_q] <= 1'b1;
                addr_q[fill_sel_q] <= line_base_q + 21'(x_q) - 21'd31;
                fill_sel_q         <= ~fill_sel_q;
            end
        end
    end

    always_ff @(posedge i_psram_clk) begin
        if (i_psram_rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == REQ) begin
                beat_q <= '0;
            end else if ((state_q == DATA) && i_psram_data_req) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (full_q[drain_sel_q]) state_d = REQ;
            REQ:  if (i_psram_gnt) state_d = DATA;
            DATA: if (release_now) state_d = full_q[~drain_sel_q] ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_psram_req  = (state_q == REQ);
    assign o_psram_addr = addr_q[drain_sel_q];
    assign o_psram_data = (state_q == DATA) ? buf_mem[drain_sel_q][beat_q] : 64'd0;
    assign o_busy       = (|full_q) || (state_q != IDLE);
    assign o_overflow   = overflow_q;
    assign o_align_err  = align_err_q;

endmodule
